oam_dma: RTL and testbench

//  OAM DMA engine feeding the memory arbiter. A CPU write to FF46 starts a
//  160-byte copy from {src,8'h00}..{src,8'h9F} into OAM 00..9F. Per byte it

---
 rtl/oam_dma_pkg.sv | 26 ++
 rtl/oam_dma_if.sv | 23 ++
 rtl/oam_dma_timer.sv | 44 ++++
 rtl/oam_dma.sv | 102 ++++++++++
 tb/tb_oam_dma.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/oam_dma_pkg.sv
// Shared constants, state encoding and source-address helpers for the OAM DMA engine.
package oam_dma_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam int          DMA_LEN      = 160;
  localparam logic [7:0]  VRAM_HI_MIN  = 8'h80;
  localparam logic [7:0]  VRAM_HI_MAX  = 8'h9F;
  localparam logic [7:0]  ECHO_FOLD    = 8'hE0;
  localparam logic [7:0]  ECHO_OFS     = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER
  } dma_state_t;

  // Pages E0..FF mirror C0..DF, so fold them before they reach the bus.
  function automatic logic [7:0] fold_src(input logic [7:0] v);
    return (v >= ECHO_FOLD) ? (v - ECHO_OFS) : v;
  endfunction

  function automatic logic is_vram(input logic [7:0] v);
    return (v >= VRAM_HI_MIN) && (v <= VRAM_HI_MAX);
  endfunction

endpackage

// File: rtl/oam_dma_if.sv
// SoC register-write port and DMA source/destination bus of the OAM DMA engine.
interface oam_dma_if;
  logic        soc_wr;
  logic [15:0] a;
  logic [7:0]  d;
  logic [7:0]  reg_q;
  logic        dma_run;
  logic [15:0] dma_a;
  logic        dma_addr_ext;
  logic        vram_to_oam;
  logic [7:0]  oam_a;
  logic        oam_wr;

  modport master (
    output soc_wr, a, d,
    input  reg_q, dma_run, dma_a, dma_addr_ext, vram_to_oam, oam_a, oam_wr
  );

  modport slave (
    input  soc_wr, a, d,
    output reg_q, dma_run, dma_a, dma_addr_ext, vram_to_oam, oam_a, oam_wr
  );
endinterface

// File: rtl/oam_dma_timer.sv
// Start-delay down-counter and per-byte step counter for the OAM DMA engine.
module oam_dma_timer #(
  parameter int STEP_CLKS = 4,
  parameter int START_DLY = 4
) (
  input  logic clk2,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic start_go,
  output logic step_last
);

  localparam int DW = $clog2(START_DLY + 1);
  localparam int SW = $clog2(STEP_CLKS);

  logic [DW-1:0] dly;
  logic [SW-1:0] step;
  logic          armed;

  // A fresh load in the same cycle wins over an expiring delay.
  assign start_go  = armed && (dly == '0) && !load;
  assign step_last = run && (step == SW'(STEP_CLKS - 1));

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      dly   <= '0;
      armed <= 1'b0;
      step  <= '0;
    end else begin
      if (load) begin
        armed <= 1'b1;
        dly   <= DW'(START_DLY - 1);
      end else if (armed) begin
        if (dly == '0) armed <= 1'b0;
        else           dly   <= dly - DW'(1);
      end

      if (start_go || !run || step_last) step <= '0;
      else                               step <= step + SW'(1);
    end
  end

endmodule

// File: rtl/oam_dma.sv
// OAM DMA engine: FF46 write detect, control FSM, source/destination address regs.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int STEP_CLKS = 4,
  parameter int START_DLY = 4
) (
  input  logic        clk2,
  input  logic        reset,
  oam_dma_if.slave    bus
);

  dma_state_t state, state_nx;

  logic       hit, wr_prev, ev;
  logic       start_go, step_last, last_byte, run;
  logic       pending;
  logic [7:0] src, src_pend, idx;

  assign hit       = bus.soc_wr && (bus.a == DMA_REG_ADDR);
  assign ev        = hit && !wr_prev;
  assign run       = (state == XFER);
  assign last_byte = step_last && (idx == 8'(DMA_LEN - 1));

  oam_dma_timer #(
    .STEP_CLKS (STEP_CLKS),
    .START_DLY (START_DLY)
  ) u_timer (
    .clk2      (clk2),
    .reset     (reset),
    .load      (ev),
    .run       (run),
    .start_go  (start_go),
    .step_last (step_last)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ev) state_nx = START;
      START:   if (start_go) state_nx = XFER;
      XFER: begin
        // A write landing on the final byte still counts as a pending restart.
        if (start_go)       state_nx = XFER;
        else if (last_byte) state_nx = (pending || ev) ? START : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wr_prev  <= 1'b0;
      pending  <= 1'b0;
      src      <= '0;
      src_pend <= '0;
      idx      <= '0;
      bus.reg_q <= '0;
    end else begin
      state   <= state_nx;
      wr_prev <= hit;

      if (ev) begin
        bus.reg_q <= bus.d;
        src_pend  <= fold_src(bus.d);
      end

      if (ev)            pending <= 1'b1;
      else if (start_go) pending <= 1'b0;

      if (start_go) begin
        src <= src_pend;
        idx <= '0;
      end else if (last_byte) begin
        idx <= '0;
      end else if (step_last) begin
        idx <= idx + 8'd1;
      end
    end
  end

  // Output stage: everything the arbiter sees is registered from the state above.
  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      bus.dma_run      <= 1'b0;
      bus.dma_a        <= '0;
      bus.oam_a        <= '0;
      bus.oam_wr       <= 1'b0;
      bus.dma_addr_ext <= 1'b0;
      bus.vram_to_oam  <= 1'b0;
    end else begin
      bus.dma_run      <= run;
      bus.dma_a        <= run ? {src, idx} : 16'h0000;
      bus.oam_a        <= run ? idx : 8'h00;
      bus.oam_wr       <= step_last;
      bus.dma_addr_ext <= run && !is_vram(src);
      bus.vram_to_oam  <= run && is_vram(src);
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma: reset, source regions, echo fold, held strobe, restart, abort.
module tb_oam_dma;

  localparam int STEP = 4;
  localparam int DLY  = 4;
  localparam int LEN  = 160;

  logic clk2 = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  oam_dma_if bus();

  oam_dma #(
    .STEP_CLKS (STEP),
    .START_DLY (DLY)
  ) dut (
    .clk2  (clk2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk2 = ~clk2;

  function automatic logic [27:0] outs();
    return {bus.dma_run, bus.dma_a, bus.oam_a, bus.oam_wr, bus.dma_addr_ext, bus.vram_to_oam};
  endfunction

  task automatic check_idle(input string name);
    n_assert++;
    if (outs() !== 28'd0) begin
      n_fail++;
      $display("FAIL %s: outputs=%h required=0", name, outs());
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=%h required=%h", name, got, want);
    end
  endtask

  // Called at a negedge; returns at the negedge following the sampling posedge.
  task automatic do_write(input logic [15:0] addr, input logic [7:0] val);
    bus.soc_wr = 1'b1;
    bus.a      = addr;
    bus.d      = val;
    @(negedge clk2);
    bus.soc_wr = 1'b0;
    bus.a      = 16'h0000;
    bus.d      = 8'h00;
  endtask

  // Checks the start delay; returns on the first negedge where the run is visible.
  task automatic wait_start(input string name);
    for (int k = 1; k <= DLY; k++) begin
      @(negedge clk2);
      n_assert++;
      if (bus.dma_run !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_delay k=%0d: dma_run=%b required=0", name, k, bus.dma_run);
      end
    end
    @(negedge clk2);
  endtask

  task automatic xfer_body(input string name, input logic [7:0] src, input logic vram);
    logic [27:0] exp;
    logic [7:0]  ix;
    logic        wr;
    for (int c = 0; c < LEN * STEP; c++) begin
      if (c != 0) @(negedge clk2);
      ix  = 8'(c / STEP);
      wr  = ((c % STEP) == STEP - 1);
      exp = {1'b1, src, ix, ix, wr, ~vram, vram};
      n_assert++;
      if (outs() !== exp) begin
        n_fail++;
        $display("FAIL %s cycle=%0d: outputs=%h required=%h", name, c, outs(), exp);
      end
    end
    @(negedge clk2);
    check_idle({name, "_end"});
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.soc_wr = 1'b0;
    bus.a      = 16'h0000;
    bus.d      = 8'h00;
    repeat (3) @(negedge clk2);
    check_idle("reset_outs");
    check_byte("reset_reg_q", bus.reg_q, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk2);
    check_idle("post_reset_outs");
  endtask

  task automatic test_ext();
    do_write(16'hFF46, 8'hC1);
    check_byte("ext_reg_q", bus.reg_q, 8'hC1);
    wait_start("ext");
    xfer_body("ext", 8'hC1, 1'b0);
  endtask

  task automatic test_vram();
    do_write(16'hFF46, 8'h88);
    check_byte("vram_reg_q", bus.reg_q, 8'h88);
    wait_start("vram");
    xfer_body("vram", 8'h88, 1'b1);
  endtask

  task automatic test_echo();
    do_write(16'hFF46, 8'hF0);
    check_byte("echo_reg_q", bus.reg_q, 8'hF0);
    wait_start("echo");
    xfer_body("echo", 8'hD0, 1'b0);
  endtask

  task automatic test_other_addr();
    do_write(16'hFF47, 8'h33);
    repeat (DLY + 4) @(negedge clk2);
    check_idle("other_addr_outs");
    check_byte("other_addr_reg_q", bus.reg_q, 8'hF0);
  endtask

  task automatic test_held();
    int          wr_cnt = 0;
    int          rises  = 0;
    logic        prev   = 1'b0;
    logic [15:0] first_a = 16'h0000;
    bus.soc_wr = 1'b1;
    bus.a      = 16'hFF46;
    bus.d      = 8'hC3;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk2);
      if (i == 9) begin
        bus.soc_wr = 1'b0;
        bus.a      = 16'h0000;
        bus.d      = 8'h00;
      end
      if (bus.oam_wr === 1'b1) wr_cnt++;
      if (bus.dma_run === 1'b1 && !prev) begin
        rises++;
        if (rises == 1) first_a = bus.dma_a;
      end
      prev = bus.dma_run;
    end
    n_assert++;
    if (wr_cnt !== LEN) begin
      n_fail++;
      $display("FAIL held_wr_count: got=%0d required=%0d", wr_cnt, LEN);
    end
    n_assert++;
    if (rises !== 1) begin
      n_fail++;
      $display("FAIL held_run_count: got=%0d required=1", rises);
    end
    n_assert++;
    if (first_a !== 16'hC300) begin
      n_fail++;
      $display("FAIL held_first_a: got=%h required=C300", first_a);
    end
    check_idle("held_end");
  endtask

  task automatic test_restart();
    do_write(16'hFF46, 8'hC0);
    wait_start("restart_first");
    n_assert++;
    if (bus.dma_a !== 16'hC000) begin
      n_fail++;
      $display("FAIL restart_first_a: got=%h required=C000", bus.dma_a);
    end
    repeat (50 * STEP) @(negedge clk2);
    check_byte("restart_idx50", bus.oam_a, 8'd50);
    do_write(16'hFF46, 8'hC2);
    for (int k = 1; k <= DLY; k++) begin
      @(negedge clk2);
      n_assert++;
      if (bus.dma_run !== 1'b1 || bus.dma_a[15:8] !== 8'hC0) begin
        n_fail++;
        $display("FAIL restart_old k=%0d: run=%b dma_a=%h required run=1 page=C0", k, bus.dma_run, bus.dma_a);
      end
    end
    @(negedge clk2);
    xfer_body("restart_new", 8'hC2, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_write(16'hFF46, 8'hC4);
    wait_start("abort");
    repeat (80 * STEP) @(negedge clk2);
    check_byte("abort_idx80", bus.oam_a, 8'd80);
    reset = 1'b1;
    #1;
    check_idle("abort_same_cycle");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk2);
      check_idle("abort_held");
    end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk2);
      check_idle("abort_after");
    end
    check_byte("abort_reg_q", bus.reg_q, 8'h00);
    do_write(16'hFF46, 8'hC5);
    wait_start("after_abort");
    xfer_body("after_abort", 8'hC5, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ext();
    test_vram();
    test_echo();
    test_other_addr();
    test_held();
    test_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
